// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin share of one 32-bit Sklansky adder, with owner lock for multi-word carry chains.
// Latency: grant is combinational in the request cycle; sum/carry/id are registered one cycle later.
// Backpressure: requesters hold req until gnt; the result path has none (consumer samples on res_valid).
module adder_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_last,
  input  logic [32*NREQ-1:0]   A_in,
  input  logic [32*NREQ-1:0]   B_in,
  input  logic [NREQ-1:0]      Cin_in,
  output logic [NREQ-1:0]      gnt,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id,
  output logic [31:0]          S_out,
  output logic                 Cout_out,
  output logic                 lock_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_owner;
  logic [IDW-1:0]  r_res_id;
  logic            r_chain_c;
  logic            r_res_valid;
  logic            r_cout;
  logic [31:0]     r_sum;
  logic [CW-1:0]   r_idle_cnt;

  logic            w_grant;
  logic            w_timeout;
  logic [IDW-1:0]  w_sel;
  logic [IDW-1:0]  w_next_ptr;
  logic [31:0]     w_a;
  logic [31:0]     w_b;
  logic            w_cin;
  logic            w_last;
  logic [32:0]     w_add;

  // Sklansky prefix adder: carry-in is folded into bit 0's generate, so the
  // group generate of [i:0] is directly the carry out of bit i.
  function automatic logic [32:0] sklansky_add(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic        cin);
    logic [31:0] hp, g, p, gn, pn;
    hp    = a ^ b;
    g     = a & b;
    g[0]  = g[0] | (hp[0] & cin);
    p     = hp;
    for (int l = 0; l < 5; l++) begin
      gn = g;
      pn = p;
      for (int i = 0; i < 32; i++) begin
        if (((i >> l) & 1) == 1) begin
          gn[i] = g[i] | (p[i] & g[((i >> l) << l) - 1]);
          pn[i] = p[i] & p[((i >> l) << l) - 1];
        end
      end
      g = gn;
      p = pn;
    end
    return {g[31], hp ^ {g[30:0], cin}};
  endfunction

  // Arbitration and next state: round-robin search while idle, owner-only while locked.
  always_comb begin
    int idx;
    idx          = 0;
    w_grant      = 1'b0;
    w_timeout    = 1'b0;
    w_sel        = r_owner;
    w_next_state = r_state;
    if (rst_n) begin
      if (r_state == ST_IDLE) begin
        for (int i = 0; i < NREQ; i++) begin
          idx = int'(r_rr_ptr) + i;
          if (idx >= NREQ) idx = idx - NREQ;
          if (!w_grant && req[IDW'(idx)]) begin
            w_grant = 1'b1;
            w_sel   = IDW'(idx);
          end
        end
        if (w_grant && !req_last[w_sel]) w_next_state = ST_LOCKED;
      end else begin
        if (req[r_owner]) begin
          w_grant = 1'b1;
          if (req_last[r_owner]) w_next_state = ST_IDLE;
        end else if (r_idle_cnt == CW'(TIMEOUT)) begin
          // Owner stalled too long: release without granting anyone this cycle.
          w_timeout    = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
    end
  end

  assign w_next_ptr = (w_sel == IDW'(NREQ - 1)) ? '0 : w_sel + 1'b1;
  assign w_a        = A_in[{w_sel, 5'd0} +: 32];
  assign w_b        = B_in[{w_sel, 5'd0} +: 32];
  // Later beats of a locked operation continue the chain; their own Cin is ignored.
  assign w_cin      = (r_state == ST_LOCKED) ? r_chain_c : Cin_in[w_sel];
  assign w_last     = req_last[w_sel];
  assign w_add      = sklansky_add(w_a, w_b, w_cin);

  assign gnt        = w_grant ? (NREQ'(1) << w_sel) : '0;
  assign lock_err   = w_timeout;
  assign res_valid  = r_res_valid;
  assign res_id     = r_res_id;
  assign S_out      = r_sum;
  assign Cout_out   = r_cout;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Result stage, chain carry, round-robin pointer and lock idle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_chain_c   <= 1'b0;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_idle_cnt  <= '0;
    end else begin
      r_res_valid <= w_grant;
      if (w_grant) begin
        r_sum      <= w_add[31:0];
        r_cout     <= w_add[32];
        r_res_id   <= w_sel;
        r_chain_c  <= w_add[32];
        r_idle_cnt <= '0;
        if (r_state == ST_IDLE) r_owner <= w_sel;
        if (w_last)             r_rr_ptr <= w_next_ptr;
      end else if (w_timeout) begin
        r_chain_c  <= 1'b0;
        r_rr_ptr   <= w_next_ptr;
        r_idle_cnt <= '0;
      end else if (r_state == ST_LOCKED) begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model of arbitration and 33-bit arithmetic.
module tb_adder_share_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req, req_last, Cin_in;
  logic [32*NREQ-1:0]  A_in, B_in;
  logic [NREQ-1:0]     gnt;
  logic                res_valid;
  logic [IDW-1:0]      res_id;
  logic [31:0]         S_out;
  logic                Cout_out;
  logic                lock_err;

  int n_checks = 0;
  int n_pass   = 0;

  adder_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_last(req_last),
    .A_in(A_in), .B_in(B_in), .Cin_in(Cin_in), .gnt(gnt),
    .res_valid(res_valid), .res_id(res_id), .S_out(S_out),
    .Cout_out(Cout_out), .lock_err(lock_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic l);
    req[k]           = 1'b1;
    req_last[k]      = l;
    Cin_in[k]        = c;
    A_in[k*32 +: 32] = a;
    B_in[k*32 +: 32] = b;
  endtask

  task automatic do_reset();
    req      = '0;
    req_last = '0;
    rst_n    = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '1; req_last = '1; Cin_in = '1; A_in = '1; B_in = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else n_pass++;
    n_checks++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", res_valid); else n_pass++;
    n_checks++; if (res_id !== 2'd0) $display("FAIL reset_res_id: got %0d want 0", res_id); else n_pass++;
    n_checks++; if (S_out !== 32'h0) $display("FAIL reset_S_out: got %h want 0", S_out); else n_pass++;
    n_checks++; if (Cout_out !== 1'b0) $display("FAIL reset_Cout_out: got %b want 0", Cout_out); else n_pass++;
    n_checks++; if (lock_err !== 1'b0) $display("FAIL reset_lock_err: got %b want 0", lock_err); else n_pass++;
    req = '0; req_last = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    drive(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0001) $display("FAIL single_gnt: got %b want 0001", gnt); else n_pass++;
    tick(); req[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({res_valid, res_id, Cout_out, S_out} !== {1'b1, 2'd0, 1'b1, 32'h0})
      $display("FAIL single_result: got v=%b id=%0d c=%b s=%h want v=1 id=0 c=1 s=00000000",
               res_valid, res_id, Cout_out, S_out);
    else n_pass++;
    n_checks++; if (gnt !== 4'b0000) $display("FAIL single_gnt_idle: got %b want 0000", gnt); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (res_valid !== 1'b0) $display("FAIL single_strobe_width: got %b want 0", res_valid); else n_pass++;
    tick();
  endtask

  task automatic test_chain_contention();
    // rr pointer is 1 after the single op, so requester 1 wins over 2.
    drive(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    drive(2, 32'h10, 32'h20, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0010) $display("FAIL chain_gnt_beat0: got %b want 0010", gnt); else n_pass++;
    tick(); drive(1, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0010) $display("FAIL chain_gnt_beat1: got %b want 0010", gnt); else n_pass++;
    n_checks++;
    if ({res_valid, res_id, Cout_out, S_out} !== {1'b1, 2'd1, 1'b1, 32'h0})
      $display("FAIL chain_res_beat0: got v=%b id=%0d c=%b s=%h want v=1 id=1 c=1 s=00000000",
               res_valid, res_id, Cout_out, S_out);
    else n_pass++;
    tick(); req[1] = 1'b0;
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0100) $display("FAIL chain_gnt_waiter: got %b want 0100", gnt); else n_pass++;
    n_checks++;
    if ({res_valid, res_id, Cout_out, S_out} !== {1'b1, 2'd1, 1'b0, 32'h1})
      $display("FAIL chain_res_beat1: got v=%b id=%0d c=%b s=%h want v=1 id=1 c=0 s=00000001",
               res_valid, res_id, Cout_out, S_out);
    else n_pass++;
    tick(); req[2] = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({res_valid, res_id, Cout_out, S_out} !== {1'b1, 2'd2, 1'b0, 32'h30})
      $display("FAIL chain_res_waiter: got v=%b id=%0d c=%b s=%h want v=1 id=2 c=0 s=00000030",
               res_valid, res_id, Cout_out, S_out);
    else n_pass++;
    tick();
  endtask

  task automatic test_round_robin();
    logic [31:0] ra [NREQ];
    logic [31:0] rb [NREQ];
    logic        rc [NREQ];
    logic [32:0] sum;
    logic [31:0] es;
    logic        ec;
    int          eid;
    do_reset();
    for (int k = 0; k < NREQ; k++) begin
      ra[k] = $urandom; rb[k] = $urandom; rc[k] = 1'($urandom_range(0, 1));
      drive(k, ra[k], rb[k], rc[k], 1'b1);
    end
    es = '0; ec = 1'b0; eid = 0;
    for (int i = 0; i < 8; i++) begin
      int k;
      k = i % NREQ;
      @(negedge clk);
      n_checks++; if (gnt !== 4'(1 << k)) $display("FAIL rr_gnt_%0d: got %b want %b", i, gnt, 4'(1 << k)); else n_pass++;
      if (i > 0) begin
        n_checks++;
        if ({res_valid, res_id, Cout_out, S_out} !== {1'b1, 2'(eid), ec, es})
          $display("FAIL rr_res_%0d: got v=%b id=%0d c=%b s=%h want v=1 id=%0d c=%b s=%h",
                   i - 1, res_valid, res_id, Cout_out, S_out, eid, ec, es);
        else n_pass++;
      end
      sum = {1'b0, ra[k]} + {1'b0, rb[k]} + {32'b0, rc[k]};
      es = sum[31:0]; ec = sum[32]; eid = k;
      tick();
      ra[k] = $urandom; rb[k] = $urandom; rc[k] = 1'($urandom_range(0, 1));
      drive(k, ra[k], rb[k], rc[k], 1'b1);
    end
    req = '0;
    @(negedge clk);
    n_checks++;
    if ({res_valid, res_id, Cout_out, S_out} !== {1'b1, 2'(eid), ec, es})
      $display("FAIL rr_res_7: got v=%b id=%0d c=%b s=%h want v=1 id=%0d c=%b s=%h",
               res_valid, res_id, Cout_out, S_out, eid, ec, es);
    else n_pass++;
    tick();
  endtask

  task automatic test_cin_locked();
    // rr pointer is back at 0; requester 3 is the only one asking.
    drive(3, 32'h1, 32'h1, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++; if (gnt !== 4'b1000) $display("FAIL cin_gnt_beat0: got %b want 1000", gnt); else n_pass++;
    tick(); drive(3, 32'h1, 32'h1, 1'b1, 1'b1);
    @(negedge clk);
    n_checks++;
    if ({res_valid, res_id, Cout_out, S_out} !== {1'b1, 2'd3, 1'b0, 32'h3})
      $display("FAIL cin_res_beat0: got v=%b id=%0d c=%b s=%h want v=1 id=3 c=0 s=00000003",
               res_valid, res_id, Cout_out, S_out);
    else n_pass++;
    tick(); req[3] = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({res_valid, res_id, Cout_out, S_out} !== {1'b1, 2'd3, 1'b0, 32'h2})
      $display("FAIL cin_res_beat1: got v=%b id=%0d c=%b s=%h want v=1 id=3 c=0 s=00000002",
               res_valid, res_id, Cout_out, S_out);
    else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    drive(0, 32'h5, 32'h7, 1'b0, 1'b0);
    drive(3, 32'h9, 32'h9, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0001) $display("FAIL to_gnt_beat0: got %b want 0001", gnt); else n_pass++;
    tick(); req[0] = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_checks++;
        if ({res_valid, res_id, Cout_out, S_out} !== {1'b1, 2'd0, 1'b0, 32'hC})
          $display("FAIL to_res_beat0: got v=%b id=%0d c=%b s=%h want v=1 id=0 c=0 s=0000000c",
                   res_valid, res_id, Cout_out, S_out);
        else n_pass++;
      end
      if (gnt !== 4'b0000 || lock_err !== 1'b0) bad++;
      tick();
    end
    n_checks++; if (bad !== 0) $display("FAIL to_idle_window: got %0d early grant/err cycles want 0", bad); else n_pass++;
    @(negedge clk);
    n_checks++; if (lock_err !== 1'b1) $display("FAIL to_lock_err: got %b want 1", lock_err); else n_pass++;
    n_checks++; if (gnt !== 4'b0000) $display("FAIL to_gnt_release: got %b want 0000", gnt); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (gnt !== 4'b1000) $display("FAIL to_gnt_next: got %b want 1000", gnt); else n_pass++;
    n_checks++; if (lock_err !== 1'b0) $display("FAIL to_lock_err_width: got %b want 0", lock_err); else n_pass++;
    tick(); req[3] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_chain();
    drive(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0100) $display("FAIL rst_gnt_beat0: got %b want 0100", gnt); else n_pass++;
    tick(); req[2] = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({gnt, res_valid, res_id, Cout_out, S_out, lock_err} !== '0)
      $display("FAIL rst_mid_outputs: got gnt=%b v=%b id=%0d c=%b s=%h err=%b want all 0",
               gnt, res_valid, res_id, Cout_out, S_out, lock_err);
    else n_pass++;
    tick(); rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (res_valid !== 1'b0) $display("FAIL rst_no_stale_result: got %b want 0", res_valid); else n_pass++;
    tick(); drive(1, 32'h5, 32'h6, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0010) $display("FAIL rst_gnt_after: got %b want 0010", gnt); else n_pass++;
    tick(); req[1] = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({res_valid, res_id, Cout_out, S_out} !== {1'b1, 2'd1, 1'b0, 32'hB})
      $display("FAIL rst_res_after: got v=%b id=%0d c=%b s=%h want v=1 id=1 c=0 s=0000000b",
               res_valid, res_id, Cout_out, S_out);
    else n_pass++;
    tick();
  endtask

  task automatic test_random_traffic();
    logic        act  [NREQ];
    int          left [NREQ];
    logic [31:0] ra   [NREQ];
    logic [31:0] rb   [NREQ];
    logic        rc   [NREQ];
    logic        m_locked, m_carry, exp_v, ec, cin;
    int          m_owner, m_rr, k, eid;
    logic [31:0] es;
    logic [32:0] sum;
    do_reset();
    for (int j = 0; j < NREQ; j++) begin act[j] = 1'b0; left[j] = 0; ra[j] = '0; rb[j] = '0; rc[j] = 1'b0; end
    m_locked = 1'b0; m_carry = 1'b0; m_owner = 0; m_rr = 0;
    exp_v = 1'b0; ec = 1'b0; es = '0; eid = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!act[j] && $urandom_range(0, 2) == 0) begin
          act[j]  = 1'b1;
          left[j] = int'($urandom_range(1, 3));
          ra[j]   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
          rb[j]   = $urandom;
          rc[j]   = 1'($urandom_range(0, 1));
        end
        req[j] = act[j];
        req_last[j] = (left[j] == 1);
        Cin_in[j] = rc[j];
        A_in[j*32 +: 32] = ra[j];
        B_in[j*32 +: 32] = rb[j];
      end
      @(negedge clk);
      n_checks++;
      if (exp_v) begin
        if ({res_valid, res_id, Cout_out, S_out} !== {1'b1, 2'(eid), ec, es})
          $display("FAIL rand_res_c%0d: got v=%b id=%0d c=%b s=%h want v=1 id=%0d c=%b s=%h",
                   cyc, res_valid, res_id, Cout_out, S_out, eid, ec, es);
        else n_pass++;
      end else begin
        if (res_valid !== 1'b0) $display("FAIL rand_res_c%0d: got v=%b want v=0", cyc, res_valid);
        else n_pass++;
      end
      // Expected winner from the arbitration rules.
      k = -1;
      if (m_locked) begin
        if (act[m_owner]) k = m_owner;
      end else begin
        for (int s = 0; s < NREQ; s++)
          if (k < 0 && act[(m_rr + s) % NREQ]) k = (m_rr + s) % NREQ;
      end
      n_checks++;
      if (gnt !== ((k >= 0) ? 4'(1 << k) : 4'b0000))
        $display("FAIL rand_gnt_c%0d: got %b want %b", cyc, gnt, (k >= 0) ? 4'(1 << k) : 4'b0000);
      else n_pass++;
      n_checks++; if (lock_err !== 1'b0) $display("FAIL rand_lock_err_c%0d: got %b want 0", cyc, lock_err); else n_pass++;
      exp_v = (k >= 0);
      if (k >= 0) begin
        cin = m_locked ? m_carry : rc[k];
        sum = {1'b0, ra[k]} + {1'b0, rb[k]} + {32'b0, cin};
        es = sum[31:0]; ec = sum[32]; eid = k;
        m_carry = sum[32];
        if (left[k] == 1) begin
          m_locked = 1'b0;
          m_rr = (k + 1) % NREQ;
        end else begin
          m_locked = 1'b1;
          m_owner = k;
        end
        left[k]--;
        if (left[k] == 0) act[k] = 1'b0;
        else begin
          ra[k] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
          rb[k] = $urandom;
          rc[k] = 1'($urandom_range(0, 1));
        end
      end
      tick();
    end
    req = '0;
    @(negedge clk);
    n_checks++;
    if (exp_v && {res_valid, res_id, Cout_out, S_out} !== {1'b1, 2'(eid), ec, es})
      $display("FAIL rand_res_final: got v=%b id=%0d c=%b s=%h want v=1 id=%0d c=%b s=%h",
               res_valid, res_id, Cout_out, S_out, eid, ec, es);
    else if (!exp_v && res_valid !== 1'b0)
      $display("FAIL rand_res_final: got v=%b want v=0", res_valid);
    else n_pass++;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_chain_contention();
    test_round_robin();
    test_cin_locked();
    test_timeout();
    test_reset_mid_chain();
    test_random_traffic();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
